coin_accumulator: RTL and testbench

Coin-input front end for the vending machine. It debounces and validates coin-sensor events, accepts or rejects each coin over a valid/ack handshake, and keeps a saturating running credit total. The total drives the vending FSM's `i_total_coin_value` input. The vending FSM gates acceptance with `i_enable` and zeroes the credit with `i_clear` after a dispense or cancel.

---
 rtl/coin_accumulator.sv | 120 ++++++++++++
 tb/tb_coin_accumulator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/coin_accumulator.sv
// Coin-input front end: debounces the coin sensor, accepts or rejects each coin over a
// valid/ack handshake and keeps a saturating running credit total and coin count.
module coin_accumulator #(
  parameter logic [6:0]  COIN_A_VALUE    = 7'd1,
  parameter logic [6:0]  COIN_B_VALUE    = 7'd2,
  parameter logic [6:0]  COIN_C_VALUE    = 7'd5,
  parameter logic [6:0]  COIN_D_VALUE    = 7'd10,
  parameter logic [6:0]  MAX_TOTAL       = 7'd100,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic       i_coin_valid,
  input  logic [1:0] i_coin_type,
  output logic       o_coin_ack,
  output logic       o_coin_accepted,
  output logic       o_coin_rejected,
  output logic [6:0] o_total_coin_value,
  output logic [3:0] o_coin_count,
  output logic       o_busy
);

  typedef enum logic [2:0] {StIdle, StEval, StAccept, StReject, StRelease} state_e;

  localparam logic [3:0] DebTarget = 4'(DEBOUNCE_CYCLES);

  state_e     state_q;
  logic [3:0] deb_q;
  logic [1:0] type_q;
  logic [6:0] total_q;
  logic [3:0] count_q;
  logic       ack_q, acc_q, rej_q;

  logic [6:0] coin_value;
  logic [7:0] sum;
  logic       accept_ok;

  always_comb begin
    coin_value = COIN_A_VALUE;
    unique case (type_q)
      2'b00: coin_value = COIN_A_VALUE;
      2'b01: coin_value = COIN_B_VALUE;
      2'b10: coin_value = COIN_C_VALUE;
      2'b11: coin_value = COIN_D_VALUE;
    endcase
    // 8-bit sum so the MAX_TOTAL comparison never sees a wrapped value
    sum       = {1'b0, total_q} + {1'b0, coin_value};
    accept_ok = i_enable && !i_clear && (sum <= {1'b0, MAX_TOTAL}) && (count_q != 4'd15);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      deb_q   <= 4'd0;
      type_q  <= 2'b00;
      total_q <= 7'd0;
      count_q <= 4'd0;
      ack_q   <= 1'b0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      acc_q <= 1'b0;
      rej_q <= 1'b0;
      // Clear applies in every state; ACCEPT below overrides it so the coin is kept
      if (i_clear) begin
        total_q <= 7'd0;
        count_q <= 4'd0;
      end
      case (state_q)
        StIdle: begin
          if (i_coin_valid) begin
            if (deb_q + 4'd1 == DebTarget) begin
              type_q  <= i_coin_type;
              deb_q   <= 4'd0;
              state_q <= StEval;
            end else begin
              deb_q <= deb_q + 4'd1;
            end
          end else begin
            deb_q <= 4'd0;
          end
        end
        StEval: begin
          ack_q <= 1'b1;
          if (accept_ok) begin
            acc_q   <= 1'b1;
            state_q <= StAccept;
          end else begin
            rej_q   <= 1'b1;
            state_q <= StReject;
          end
        end
        StAccept: begin
          if (i_clear) begin
            total_q <= coin_value;
            count_q <= 4'd1;
          end else begin
            total_q <= sum[6:0];
            count_q <= count_q + 4'd1;
          end
          state_q <= StRelease;
        end
        StReject:  state_q <= StRelease;
        StRelease: if (!i_coin_valid) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign o_coin_ack         = ack_q;
  assign o_coin_accepted    = acc_q;
  assign o_coin_rejected    = rej_q;
  assign o_total_coin_value = total_q;
  assign o_coin_count       = count_q;
  assign o_busy             = (state_q != StIdle);

endmodule

// File: tb/tb_coin_accumulator.sv
// Scoreboard bench for coin_accumulator: stimulus pushes expected handshake outcomes,
// a monitor pops and checks them whenever the DUT acknowledges a coin.
module tb_coin_accumulator;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] ctype = 2'b00;
  logic       ack, acc, rej, busy;
  logic [6:0] total;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit acc;
    int total;
    int count;
    int cyc;
  } exp_t;

  exp_t sb[$];

  coin_accumulator dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_enable           (enable),
    .i_clear            (clear),
    .i_coin_valid       (valid),
    .i_coin_type        (ctype),
    .o_coin_ack         (ack),
    .o_coin_accepted    (acc),
    .o_coin_rejected    (rej),
    .o_total_coin_value (total),
    .o_coin_count       (count),
    .o_busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops one expectation; totals are checked one cycle later
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (acc && rej) check("pulses_exclusive", 1, 0);
        if ((acc || rej) && !ack) check("pulse_without_ack", 0, 1);
        if (ack) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", 1, 0);
          end else begin
            e = sb.pop_front();
            check("accepted", int'(acc), int'(e.acc));
            check("rejected", int'(rej), int'(!e.acc));
            check("ack_cycle", cyc, e.cyc);
            @(negedge clk);
            check("total", int'(total), e.total);
            check("count", int'(count), e.count);
          end
        end
      end
    end
  end

  // clr_off: clear held high during the cycle right after edge clr_off (edge 0 = first sample)
  task automatic insert(input logic [1:0] t, input bit exp_acc, input int exp_total,
                        input int exp_count, input int clr_off);
    exp_t e;
    int n;
    @(posedge clk); #1;
    ctype = t;
    valid = 1'b1;
    e.acc = exp_acc;
    e.total = exp_total;
    e.count = exp_count;
    e.cyc = cyc + 1 + D;
    sb.push_back(e);
    for (int k = 0; k <= D + 2; k++) begin
      clear = (k - 1 == clr_off);
      @(posedge clk); #1;
    end
    clear = 1'b0;
    valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("return_to_idle", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    check("clear_total", int'(total), 0);
    check("clear_count", int'(count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_total", int'(total), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(ack), 0);
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;

    // Credit: two 10-coins
    insert(2'b11, 1'b1, 10, 1, -100);
    insert(2'b11, 1'b1, 20, 2, -100);

    // Glitch: two high samples only
    @(posedge clk); #1 valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("glitch_busy", int'(busy), 0);
      @(posedge clk); #1;
    end
    check("glitch_total", int'(total), 20);

    // Reset mid-debounce, then a short valid run must not produce an ack
    @(posedge clk); #1 valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("midrst_total", int'(total), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ack", int'(ack), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (D - 1) begin
      @(posedge clk); #1;
    end
    valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("postrst_busy", int'(busy), 0);

    // Overflow: reach 95, 10 rejected, 5 fills to 100
    for (int k = 1; k <= 9; k++) insert(2'b11, 1'b1, 10 * k, k, -100);
    insert(2'b10, 1'b1, 95, 10, -100);
    insert(2'b11, 1'b0, 95, 10, -100);
    insert(2'b10, 1'b1, 100, 11, -100);

    // Gating
    clear_pulse();
    enable = 1'b0;
    insert(2'b10, 1'b0, 0, 0, -100);
    enable = 1'b1;

    // Count limit: 16th coin rejected
    for (int k = 1; k <= 15; k++) insert(2'b00, 1'b1, k, k, -100);
    insert(2'b00, 1'b0, 15, 15, -100);

    // Clear races
    clear_pulse();
    for (int k = 1; k <= 3; k++) insert(2'b11, 1'b1, 10 * k, k, -100);
    insert(2'b10, 1'b1, 5, 1, D);
    insert(2'b10, 1'b0, 0, 0, D - 1);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
